// File: rtl/xt_keyboard_buffer_pkg.sv
// Shared types and constants for the XT keyboard buffer: capture FSM
// encoding and the self-test response returned after a keyboard reset.
package xt_keyboard_buffer_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_ACK  = 2'd1,
      CAP_WAIT = 2'd2
   } cap_state_e;

   localparam logic [7:0] SELF_TEST_OK = 8'hAA;

endpackage

// File: rtl/xt_keyboard_fifo.sv
// Scancode FIFO, first-word fall-through read. Flush has priority over
// pop and may be combined with a push that becomes the sole entry.
module xt_keyboard_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int PTR_W = DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_idx;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && (flush_i || !full_o);
      do_pop   = pop_i && !flush_i && !empty_o;
      wr_idx   = flush_i ? '0 : wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = do_push ? PTR_W'(1) : '0;
         count_d  = do_push ? CNT_W'(1) : '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only; occupancy is tracked by count_q.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_idx] <= data_i;
   end

endmodule

// File: rtl/xt_keyboard_buffer.sv
// XT keyboard buffer: captures converter scancodes into a FIFO and presents
// them on 8255 port A / IRQ1, handling PB7 acknowledge and PB6 keyboard reset.
module xt_keyboard_buffer
   import xt_keyboard_buffer_pkg::*;
#(
   parameter int          FIFO_DEPTH_LOG2   = 4,
   parameter logic [15:0] RESET_HOLD_CYCLES = 16'd1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       kb_irq,
   input  logic [7:0] kb_keycode,
   output logic       kb_clear,
   input  logic       port_b_clear,
   input  logic       port_b_clk_enable,
   output logic [7:0] port_a_data,
   output logic       irq1,
   output logic       fifo_full
);

   cap_state_e  state_q, state_d;
   logic        cap_push;
   logic        fifo_push, fifo_pop, fifo_empty, fifo_full_w;
   logic [7:0]  fifo_wdata, fifo_rdata;
   logic        pb6_q;
   logic [15:0] low_cnt_q, low_cnt_d;
   logic        reset_seq;
   logic        latch_full_q, latch_full_d;
   logic [7:0]  port_a_q, port_a_d;

   assign reset_seq = port_b_clk_enable && !pb6_q && (low_cnt_q >= RESET_HOLD_CYCLES);

   // A capture is deferred during the self-test cycle so 0xAA stays the sole entry.
   always_comb begin
      state_d  = state_q;
      kb_clear = 1'b0;
      cap_push = 1'b0;
      case (state_q)
         CAP_IDLE: begin
            if (kb_irq && !reset_seq && (!fifo_full_w || !port_b_clk_enable)) begin
               cap_push = port_b_clk_enable;
               state_d  = CAP_ACK;
            end
         end
         CAP_ACK: begin
            kb_clear = 1'b1;
            state_d  = CAP_WAIT;
         end
         CAP_WAIT: state_d = CAP_IDLE;
         default:  state_d = CAP_IDLE;
      endcase
   end

   always_comb begin
      fifo_push  = cap_push || reset_seq;
      fifo_wdata = reset_seq ? SELF_TEST_OK : kb_keycode;
      fifo_pop   = !latch_full_q && !fifo_empty && !port_b_clear && !reset_seq;
      if (!port_b_clk_enable)
         low_cnt_d = (low_cnt_q == 16'hFFFF) ? low_cnt_q : low_cnt_q + 16'd1;
      else
         low_cnt_d = 16'd0;
      latch_full_d = latch_full_q;
      port_a_d     = port_a_q;
      if (port_b_clear) begin
         latch_full_d = 1'b0;
         port_a_d     = 8'h00;
      end else if (fifo_pop) begin
         latch_full_d = 1'b1;
         port_a_d     = fifo_rdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= CAP_IDLE;
         pb6_q        <= 1'b1;
         low_cnt_q    <= 16'd0;
         latch_full_q <= 1'b0;
         port_a_q     <= 8'h00;
      end else begin
         state_q      <= state_d;
         pb6_q        <= port_b_clk_enable;
         low_cnt_q    <= low_cnt_d;
         latch_full_q <= latch_full_d;
         port_a_q     <= port_a_d;
      end
   end

   xt_keyboard_fifo #(
      .DEPTH_LOG2(FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push_i (fifo_push),
      .pop_i  (fifo_pop),
      .flush_i(reset_seq),
      .data_i (fifo_wdata),
      .data_o (fifo_rdata),
      .full_o (fifo_full_w),
      .empty_o(fifo_empty)
   );

   assign port_a_data = port_a_q;
   assign irq1        = latch_full_q;
   assign fifo_full   = fifo_full_w;

endmodule

// File: tb/tb_xt_keyboard_buffer.sv
// Bench for xt_keyboard_buffer: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_xt_keyboard_buffer;

   logic       clock = 1'b0;
   logic       reset;
   logic       kb_irq;
   logic [7:0] kb_keycode;
   logic       kb_clear;
   logic       port_b_clear;
   logic       port_b_clk_enable;
   logic [7:0] port_a_data;
   logic       irq1;
   logic       fifo_full;

   int checks = 0;
   int errors = 0;

   xt_keyboard_buffer dut (
      .clock            (clock),
      .reset            (reset),
      .kb_irq           (kb_irq),
      .kb_keycode       (kb_keycode),
      .kb_clear         (kb_clear),
      .port_b_clear     (port_b_clear),
      .port_b_clk_enable(port_b_clk_enable),
      .port_a_data      (port_a_data),
      .irq1             (irq1),
      .fifo_full        (fifo_full)
   );

   always #5 clock = ~clock;

   // Reference model: scancode queue, presentation latch, capture busy time
   // (2 = acknowledging, 1 = waiting) and length of the current PB6-low run.
   byte unsigned mq[$];
   bit           m_latch;
   byte unsigned m_pa;
   int           m_busy;
   int           m_low;
   bit           m_pb6p;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_latch = 1'b0;
      m_pa    = 8'h00;
      m_busy  = 0;
      m_low   = 0;
      m_pb6p  = 1'b1;
   endtask

   task automatic model_edge();
      bit full, rs, cap, pop;
      full = (mq.size() == 16);
      rs   = port_b_clk_enable && !m_pb6p && (m_low >= 1000);
      cap  = (m_busy == 0) && kb_irq && !rs && (!full || !port_b_clk_enable);
      pop  = !m_latch && (mq.size() > 0) && !port_b_clear && !rs;
      if (port_b_clear) begin
         m_latch = 1'b0;
         m_pa    = 8'h00;
      end else if (pop) begin
         m_pa    = mq.pop_front();
         m_latch = 1'b1;
      end
      if (rs) begin
         mq.delete();
         mq.push_back(8'hAA);
      end else if (cap && port_b_clk_enable) begin
         mq.push_back(kb_keycode);
      end
      if (port_b_clk_enable) m_low = 0;
      else if (m_low < 65535) m_low = m_low + 1;
      m_pb6p = port_b_clk_enable;
      if (m_busy > 0) m_busy = m_busy - 1;
      else if (cap) m_busy = 2;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      chk("kb_clear", int'(kb_clear), int'(m_busy == 2));
      chk("port_a_data", int'(port_a_data), int'(m_pa));
      chk("irq1", int'(irq1), int'(m_latch));
      chk("fifo_full", int'(fifo_full), int'(mq.size() == 16));
   endtask

   task automatic send_code(input logic [7:0] c);
      bit got;
      got = 1'b0;
      kb_irq = 1'b1;
      kb_keycode = c;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (kb_clear) got = 1'b1;
      end
      kb_irq = 1'b0;
      chk("send_ack", int'(got), 1);
   endtask

   typedef struct {
      bit           irq;
      byte unsigned code;
      bit           pb7;
      bit           e_clr;
      byte unsigned e_pa;
      bit           e_irq1;
   } vec_t;

   vec_t tv[6];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int low_left;

      tv[0] = '{1'b1, 8'h1E, 1'b0, 1'b1, 8'h00, 1'b0};
      tv[1] = '{1'b1, 8'h1E, 1'b0, 1'b0, 8'h1E, 1'b1};
      tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1E, 1'b1};
      tv[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1E, 1'b1};
      tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      tv[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

      kb_irq = 1'b0;
      kb_keycode = 8'h00;
      port_b_clear = 1'b0;
      port_b_clk_enable = 1'b1;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_kb_clear", int'(kb_clear), 0);
      chk("rst_port_a", int'(port_a_data), 0);
      chk("rst_irq1", int'(irq1), 0);
      chk("rst_fifo_full", int'(fifo_full), 0);
      reset = 1'b0;
      step();

      // single code, table driven
      foreach (tv[i]) begin
         kb_irq = tv[i].irq;
         kb_keycode = tv[i].code;
         port_b_clear = tv[i].pb7;
         step();
         chk("tv_kb_clear", int'(kb_clear), int'(tv[i].e_clr));
         chk("tv_port_a", int'(port_a_data), int'(tv[i].e_pa));
         chk("tv_irq1", int'(irq1), int'(tv[i].e_irq1));
      end

      // burst held back by PB7, then released one per PB7 pulse
      port_b_clear = 1'b1;
      for (int i = 0; i < 5; i++) send_code(8'h10 + 8'(i));
      repeat (3) step();
      chk("burst_held_irq1", int'(irq1), 0);
      port_b_clear = 1'b0;
      step();
      chk("burst_first", int'(port_a_data), 8'h10);
      for (int i = 1; i < 5; i++) begin
         port_b_clear = 1'b1;
         step();
         chk("burst_pb7_clears", int'(irq1), 0);
         port_b_clear = 1'b0;
         step();
         chk("burst_next", int'(port_a_data), 8'h10 + i);
         chk("burst_next_irq1", int'(irq1), 1);
      end

      // overflow: 16 accepted, 17th held without ack until a slot frees
      port_b_clear = 1'b1;
      for (int i = 0; i < 16; i++) send_code(8'h40 + 8'(i));
      step();
      chk("ovf_full", int'(fifo_full), 1);
      kb_irq = 1'b1;
      kb_keycode = 8'h50;
      repeat (6) begin
         step();
         chk("ovf_no_ack", int'(kb_clear), 0);
      end
      port_b_clear = 1'b0;
      step();
      chk("ovf_pop", int'(port_a_data), 8'h40);
      port_b_clear = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (kb_clear) got = 1'b1;
      end
      kb_irq = 1'b0;
      chk("ovf_late_ack", int'(got), 1);
      repeat (2) step();
      chk("ovf_full_again", int'(fifo_full), 1);

      // 999-cycle PB6 pulse: no effect
      port_b_clk_enable = 1'b0;
      repeat (999) step();
      port_b_clk_enable = 1'b1;
      repeat (3) step();
      chk("short_pb6_keeps", int'(fifo_full), 1);
      chk("short_pb6_irq1", int'(irq1), 0);

      // 1000-cycle PB6 pulse: flush, 0xAA two cycles after release
      port_b_clk_enable = 1'b0;
      repeat (1000) step();
      port_b_clk_enable = 1'b1;
      port_b_clear = 1'b0;
      step();
      chk("kbrst_not_yet", int'(irq1), 0);
      step();
      chk("kbrst_aa", int'(port_a_data), 8'hAA);
      chk("kbrst_irq1", int'(irq1), 1);
      chk("kbrst_flushed", int'(fifo_full), 0);
      port_b_clear = 1'b1;
      step();
      port_b_clear = 1'b0;
      repeat (3) step();
      chk("kbrst_sole_entry", int'(irq1), 0);

      // codes during PB6 low are acked and discarded
      port_b_clk_enable = 1'b0;
      send_code(8'h33);
      send_code(8'h34);
      port_b_clk_enable = 1'b1;
      repeat (4) step();
      chk("pb6low_discard", int'(irq1), 0);

      // async reset while acknowledging, FIFO non-empty
      port_b_clear = 1'b1;
      send_code(8'h61);
      send_code(8'h62);
      repeat (2) step();
      kb_irq = 1'b1;
      kb_keycode = 8'h5A;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (kb_clear) got = 1'b1;
      end
      chk("arst_reach_ack", int'(got), 1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("arst_kb_clear", int'(kb_clear), 0);
      chk("arst_port_a", int'(port_a_data), 0);
      chk("arst_irq1", int'(irq1), 0);
      chk("arst_full", int'(fifo_full), 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      port_b_clear = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (kb_clear) got = 1'b1;
      end
      kb_irq = 1'b0;
      chk("arst_recapture", int'(got), 1);
      step();
      chk("arst_fifo_was_empty", int'(port_a_data), 8'h5A);
      chk("arst_irq1_after", int'(irq1), 1);

      // randomized traffic against the model
      low_left = 0;
      for (int n = 0; n < 9000; n++) begin
         if (low_left > 0) begin
            low_left--;
            if (low_left == 0) port_b_clk_enable = 1'b1;
         end else if ($urandom_range(0, 899) == 0) begin
            port_b_clk_enable = 1'b0;
            low_left = $urandom_range(990, 1010);
         end
         if ($urandom_range(0, 7) == 0) port_b_clear = ~port_b_clear;
         if (!kb_irq && $urandom_range(0, 3) == 0) begin
            kb_irq = 1'b1;
            kb_keycode = 8'($urandom);
         end
         step();
         if (kb_clear) kb_irq = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xt_keyboard_buffer.md
# xt_keyboard_buffer

Downstream stage of the PS/2 keyboard converter: accepts translated XT scancodes (level `irq` + `keycode`, acknowledged via `clear_keycode`), queues them in a small FIFO and presents them to the 8255 port A / IRQ1 path with original XT semantics. It handles PB7 (clear/acknowledge) and PB6 (keyboard clock enable), including the BIOS keyboard-reset sequence that must return 0xAA. Sits between the converter and the PPI/PIC glue.

## Interface
- `FIFO_DEPTH_LOG2`, default 4: FIFO holds 2^N scancodes (16).
- `RESET_HOLD_CYCLES`, default 16'd1000: minimum PB6-low duration, in `clock` cycles, recognised as a keyboard reset.
- `clock`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high.
- `kb_irq`  input  1  converter "code pending" level.
- `kb_keycode`  input  8  converter scancode, valid while `kb_irq`=1.
- `kb_clear`  output  1  one-cycle acknowledge to converter `clear_keycode`.
- `port_b_clear`  input  1  PB7: high clears port A latch and IRQ1, blocks presentation.
- `port_b_clk_enable`  input  1  PB6: low holds keyboard clock low (reset request).
- `port_a_data`  output  8  scancode read by CPU through port A.
- `irq1`  output  1  keyboard interrupt request, level.
- `fifo_full`  output  1  FIFO at capacity.

## Operation
- Capture FSM, states CAP_IDLE, CAP_ACK, CAP_WAIT:
  - CAP_IDLE: if `kb_irq`=1 and (FIFO not full or PB6 low): write `kb_keycode` (only if PB6 high) → CAP_ACK. If FIFO full and PB6 high: stay, no ack (converter keeps code, its own overrun logic produces 0xFF later).
  - CAP_ACK: `kb_clear`=1 → CAP_WAIT.
  - CAP_WAIT: ignore `kb_irq` (converter drops it this cycle) → CAP_IDLE.
- While PB6 low, incoming codes are acknowledged and discarded.
- Presentation: latch flag `latch_full`. When `latch_full`=0, FIFO non-empty, PB7=0: pop into `port_a_data`, set `irq1`=1, `latch_full`=1.
- PB7=1 (sampled each cycle): `port_a_data`←0x00, `irq1`←0, `latch_full`←0; no pop while PB7=1. FIFO contents untouched.
- Keyboard reset: 16-bit saturating counter increments while PB6=0, cleared while PB6=1. On PB6 0→1 with counter ≥ `RESET_HOLD_CYCLES`: flush FIFO, then write 0xAA in the same cycle (flush wins, 0xAA is sole entry). Shorter pulses: no effect.
- FIFO: simultaneous push and pop legal at any occupancy except push-when-full (blocked above); count arithmetic width `FIFO_DEPTH_LOG2`+1; pointers wrap modulo 2^N.

## Timing
- Reset values: `port_a_data`=0x00, `irq1`=0, `kb_clear`=0, `fifo_full`=0, FIFO empty, FSM CAP_IDLE, counter 0, `latch_full`=0.
- `kb_irq` high in cycle N (CAP_IDLE) → FIFO write at end of N, `kb_clear`=1 in N+1, CAP_WAIT in N+2, next capture possible from N+3.
- Empty FIFO, empty latch, PB7=0: code captured in N appears on `port_a_data` with `irq1`=1 in N+2.
- PB7 falling edge with non-empty FIFO: next code and `irq1` one cycle after first PB7=0 cycle + 1 (pop registered, visible next cycle).
- Reset-sequence 0xAA presented 2 cycles after PB6 rises (if PB7=0, latch empty).
- Async reset mid-capture or mid-reset-sequence: all state to reset values; pending converter code is re-captured after release.

## Structure
- Shared package: capture state enum, `SELF_TEST_OK` = 8'hAA.
- Sub-module `xt_keyboard_fifo`: synchronous FIFO with push, pop, flush (flush priority, push same cycle allowed after flush), `full`, `empty`, parameterised depth. Top holds FSM, latch, reset counter.

## Test plan
- Single code: `kb_irq`=1 with 0x1E → `kb_clear` pulse 1 cycle later, `port_a_data`=0x1E and `irq1`=1 two cycles after capture; PB7 pulse → 0x00, `irq1`=0.
- Burst: 5 codes 0x10..0x14 while PB7 held high → nothing presented; PB7 low → 0x10 presented; each PB7 pulse yields next, in order.
- Overflow: 17 codes with PB7 high → `fifo_full`=1 after 16, 17th not acked (`kb_clear` stays 0), accepted once one entry popped.
- Keyboard reset: PB6 low 1000 cycles with 3 codes queued, release → FIFO flushed, `port_a_data`=0xAA, `irq1`=1; 999-cycle pulse → queue unchanged, no 0xAA.
- Codes during PB6 low → `kb_clear` pulses, no entry written.
- Async reset asserted in CAP_ACK with FIFO non-empty → all outputs reset values, FIFO empty.
